// File: rtl/clock_pkg.sv
`default_nettype none
// ============================================================================
// Module      : clock_pkg
// Description : Shared types and digit indices for the digital clock core
//               and the downstream LED scan/blink stage.
// Revision    : 1.0 - initial release
// ============================================================================
package clock_pkg;

    // Edit mode; the encoding is driven straight out as mode_flag
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        SET_SEC  = 2'd1,
        SET_MIN  = 2'd2,
        SET_HOUR = 2'd3
    } mode_t;

    typedef logic [3:0] bcd_t;

    // Positions of each BCD digit in the digits[] array
    localparam int H_T = 0;
    localparam int H_U = 1;
    localparam int M_T = 2;
    localparam int M_U = 3;
    localparam int S_T = 4;
    localparam int S_U = 5;

    // Mode sequence on each mode press: RUN -> SET_HOUR -> SET_MIN -> SET_SEC -> RUN
    function automatic mode_t next_mode(input mode_t m);
        mode_t n;
        case (m)
            RUN:      n = SET_HOUR;
            SET_HOUR: n = SET_MIN;
            SET_MIN:  n = SET_SEC;
            default:  n = RUN;
        endcase
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/button_debounce.sv
`default_nettype none
// ============================================================================
// Module      : button_debounce
// Description : Two-flop synchroniser, stability-counter debounce and a
//               one-cycle press pulse on the debounced rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 2000
) (
    input  logic clk100khz,
    input  logic rst,
    input  logic btn_raw,
    output logic press
);

    localparam int                 c_CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 1);

    logic               r_sync1;
    logic               r_sync2;
    logic               r_level;
    logic               r_level_q;
    logic               r_press;
    logic [c_CNT_W-1:0] r_cnt;

    // Bring the asynchronous button into the clock domain
    always_ff @(posedge clk100khz) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= btn_raw;
            r_sync2 <= r_sync1;
        end
    end

    // Accept a new level only after DEBOUNCE_CYCLES consecutive differing samples
    always_ff @(posedge clk100khz) begin
        if (rst) begin
            r_cnt   <= '0;
            r_level <= 1'b0;
        end else if (r_sync2 != r_level) begin
            if (r_cnt == c_CNT_LAST) begin
                r_level <= r_sync2;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + c_CNT_W'(1);
            end
        end else begin
            r_cnt <= '0;
        end
    end

    // Registered one-cycle pulse on the debounced 0->1 transition; release is silent
    always_ff @(posedge clk100khz) begin
        if (rst) begin
            r_level_q <= 1'b0;
            r_press   <= 1'b0;
        end else begin
            r_level_q <= r_level;
            r_press   <= r_level & ~r_level_q;
        end
    end

    assign press = r_press;

endmodule
`default_nettype wire

// File: rtl/time_keeper.sv
`default_nettype none
// ============================================================================
// Module      : time_keeper
// Description : 24 h HH:MM:SS BCD timekeeper with 1 Hz prescaler and a
//               two-button (mode / increment) time-setting interface.
// Revision    : 1.0 - initial release
// ============================================================================
module time_keeper
    import clock_pkg::*;
#(
    parameter int CLK_HZ          = 100000,
    parameter int DEBOUNCE_CYCLES = 2000
) (
    input  logic       clk100khz,
    input  logic       rst,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output bcd_t       digits [6],
    output logic [1:0] mode_flag,
    output logic       sec_tick
);

    localparam int                 c_PRE_W    = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [c_PRE_W-1:0] c_PRE_LAST = c_PRE_W'(CLK_HZ - 1);

    mode_t              r_mode;
    logic [c_PRE_W-1:0] r_presc;
    logic               r_sec_tick;
    bcd_t               r_digits [6];

    logic               w_mode_press;
    logic               w_inc_press;
    logic [8:0]         w_sec_inc;
    logic [8:0]         w_min_inc;
    logic [8:0]         w_hr_inc;

    // Two-digit field increment: returns {tens, units, carry}; carry marks the wrap to 00
    function automatic logic [8:0] bcd_inc(input bcd_t tens, input bcd_t units,
                                           input bcd_t max_tens, input bcd_t max_units);
        logic [8:0] r;
        if (tens == max_tens && units == max_units) begin
            r = {4'd0, 4'd0, 1'b1};
        end else if (units == 4'd9) begin
            r = {tens + 4'd1, 4'd0, 1'b0};
        end else begin
            r = {tens, units + 4'd1, 1'b0};
        end
        return r;
    endfunction

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_mode (
        .clk100khz (clk100khz),
        .rst       (rst),
        .btn_raw   (btn_mode),
        .press     (w_mode_press)
    );

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_inc (
        .clk100khz (clk100khz),
        .rst       (rst),
        .btn_raw   (btn_inc),
        .press     (w_inc_press)
    );

    // Incremented value of each field, shared by the RUN cascade and the SET edits
    always_comb begin
        w_sec_inc = bcd_inc(r_digits[S_T], r_digits[S_U], 4'd5, 4'd9);
        w_min_inc = bcd_inc(r_digits[M_T], r_digits[M_U], 4'd5, 4'd9);
        w_hr_inc  = bcd_inc(r_digits[H_T], r_digits[H_U], 4'd2, 4'd3);
    end

    // Mode FSM, prescaler, seconds cascade and field editing
    always_ff @(posedge clk100khz) begin
        if (rst) begin
            r_mode     <= RUN;
            r_presc    <= '0;
            r_sec_tick <= 1'b0;
            for (int i = 0; i < 6; i++) begin
                r_digits[i] <= '0;
            end
        end else begin
            r_sec_tick <= 1'b0;
            if (w_mode_press) begin
                // A mode change takes the whole cycle: inc is dropped and the
                // prescaler restarts so RUN always begins a full second away
                r_mode  <= next_mode(r_mode);
                r_presc <= '0;
            end else begin
                case (r_mode)
                    RUN: begin
                        if (r_presc == c_PRE_LAST) begin
                            r_presc    <= '0;
                            r_sec_tick <= 1'b1;
                            {r_digits[S_T], r_digits[S_U]} <= w_sec_inc[8:1];
                            if (w_sec_inc[0]) begin
                                {r_digits[M_T], r_digits[M_U]} <= w_min_inc[8:1];
                                if (w_min_inc[0]) begin
                                    // carry out of hours means 23 -> 00
                                    r_digits[H_T] <= w_hr_inc[0] ? 4'd0 : w_hr_inc[8:5];
                                    r_digits[H_U] <= w_hr_inc[4:1];
                                end
                            end
                        end else begin
                            r_presc <= r_presc + c_PRE_W'(1);
                        end
                    end
                    SET_SEC: begin
                        r_presc <= '0;
                        if (w_inc_press) begin
                            {r_digits[S_T], r_digits[S_U]} <= w_sec_inc[8:1];
                        end
                    end
                    SET_MIN: begin
                        r_presc <= '0;
                        if (w_inc_press) begin
                            {r_digits[M_T], r_digits[M_U]} <= w_min_inc[8:1];
                        end
                    end
                    default: begin
                        r_presc <= '0;
                        if (w_inc_press) begin
                            r_digits[H_T] <= w_hr_inc[0] ? 4'd0 : w_hr_inc[8:5];
                            r_digits[H_U] <= w_hr_inc[4:1];
                        end
                    end
                endcase
            end
        end
    end

    assign digits    = r_digits;
    assign mode_flag = r_mode;
    assign sec_tick  = r_sec_tick;

endmodule
`default_nettype wire
